// File: rtl/nios2_dbg_sysclk_cmd_queue.sv
// System-clock side of the Nios II JTAG debug bridge: synchronises the update-DR/update-IR
// strobes, queues {ir, dr} commands in a FWFT FIFO and hands them out with one-hot action pulses.
module nios2_dbg_sysclk_cmd_queue #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [IR_W-1:0]                    ir_in,
    input  logic [DR_W-1:0]                    sr,
    input  logic                               vs_udr,
    input  logic                               vs_uir,
    input  logic                               cmd_ready,
    input  logic                               clr_overflow,
    output logic                               cmd_valid,
    output logic [IR_W-1:0]                    cmd_ir,
    output logic [DR_W-1:0]                    jdo,
    output logic [2**IR_W-1:0]                 take_action,
    output logic [2**IR_W-1:0]                 ir_update,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    cmd_level,
    output logic                               overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
    } entry_t;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic                   udr_edge;
    logic                   uir_edge;

    entry_t                 mem [FIFO_DEPTH];
    entry_t                 head;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic                   full;
    logic                   pop;
    logic                   accept;
    logic                   drop;

    // vs_udr/vs_uir are asynchronous levels; only the rising edge of the synchronised copy matters.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_hist <= 1'b0;
            uir_hist <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_hist;
    assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_hist;

    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign cmd_valid = (level != '0);
    assign pop       = cmd_valid & cmd_ready;
    assign accept    = udr_edge & (~full | pop);
    assign drop      = udr_edge & full & ~pop;

    // NOTE: the storage array has no reset; emptiness is tracked by level, and outputs are gated by it.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{ir: ir_in, dr: sr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear must leave the sticky bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_update <= '0;
        end else begin
            ir_update <= '0;
            if (uir_edge) begin
                ir_update[ir_in] <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign cmd_ir    = cmd_valid ? head.ir : '0;
    assign jdo       = cmd_valid ? head.dr : '0;
    assign cmd_level = level;

    // NOTE: default assignment first so the combinational block never infers a latch.
    always_comb begin
        take_action = '0;
        if (pop) begin
            take_action[cmd_ir] = 1'b1;
        end
    end

endmodule

// File: tb/tb_nios2_dbg_sysclk_cmd_queue.sv
// Directed self-checking bench for nios2_dbg_sysclk_cmd_queue with default parameters.
module tb_nios2_dbg_sysclk_cmd_queue;

    logic        clk;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr;
    logic        vs_uir;
    logic        cmd_ready;
    logic        clr_overflow;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  ir_update;
    logic [2:0]  cmd_level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    nios2_dbg_sysclk_cmd_queue dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir_in        (ir_in),
        .sr           (sr),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .cmd_ready    (cmd_ready),
        .clr_overflow (clr_overflow),
        .cmd_valid    (cmd_valid),
        .cmd_ir       (cmd_ir),
        .jdo          (jdo),
        .take_action  (take_action),
        .ir_update    (ir_update),
        .cmd_level    (cmd_level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] pat(input int i);
        return {6'(i), 32'hC0DE_0000 + 32'(i)};
    endfunction

    // One full update-DR pulse: high 5 cycles (push on 3rd edge), low 4 cycles.
    task automatic send_udr(input logic [1:0] ir, input logic [37:0] dr);
        ir_in  = ir;
        sr     = dr;
        vs_udr = 1'b1;
        repeat (5) step();
        vs_udr = 1'b0;
        repeat (4) step();
    endtask

    logic [37:0] exp_q [4];

    initial begin
        reset_n      = 1'b0;
        ir_in        = '0;
        sr           = '0;
        vs_udr       = 1'b0;
        vs_uir       = 1'b0;
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) step();
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_level", 64'(cmd_level), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_upd", 64'(ir_update), 64'd0);
        reset_n = 1'b1;
        step();

        // Single command, consumer always ready.
        cmd_ready = 1'b1;
        ir_in     = 2'd2;
        sr        = 38'h2A_5555_AAAA;
        vs_udr    = 1'b1;
        step();
        check("single_e1_valid", 64'(cmd_valid), 64'd0);
        step();
        check("single_e2_valid", 64'(cmd_valid), 64'd0);
        step();
        check("single_e3_valid", 64'(cmd_valid), 64'd1);
        check("single_e3_take", 64'(take_action), 64'b0100);
        check("single_e3_jdo", 64'(jdo), 64'(38'h2A_5555_AAAA));
        check("single_e3_ir", 64'(cmd_ir), 64'd2);
        step();
        check("single_e4_valid", 64'(cmd_valid), 64'd0);
        check("single_e4_take", 64'(take_action), 64'd0);
        check("single_e4_jdo", 64'(jdo), 64'd0);
        repeat (6) step();
        vs_udr = 1'b0;
        repeat (4) step();
        check("single_long_pulse_level", 64'(cmd_level), 64'd0);
        check("ready_empty_take", 64'(take_action), 64'd0);
        cmd_ready = 1'b0;

        // Backlog of four, then drain in order.
        for (int i = 0; i < 4; i++) send_udr(2'(i), pat(i));
        check("backlog_level", 64'(cmd_level), 64'd4);
        check("backlog_head_ir", 64'(cmd_ir), 64'd0);
        check("backlog_take_idle", 64'(take_action), 64'd0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("backlog_take%0d", i), 64'(take_action), 64'(4'b0001 << i));
            check($sformatf("backlog_jdo%0d", i), 64'(jdo), 64'(pat(i)));
            step();
        end
        check("backlog_drained", 64'(cmd_level), 64'd0);
        cmd_ready = 1'b0;

        // Overflow: fifth entry lost.
        for (int i = 0; i < 5; i++) send_udr(2'(i % 4), pat(10 + i));
        check("ovf_level", 64'(cmd_level), 64'd4);
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_head", 64'(jdo), 64'(pat(10)));
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Clear coincident with a drop: drop wins.
        ir_in  = 2'd2;
        sr     = pat(20);
        vs_udr = 1'b1;
        step();
        step();
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf_clr_vs_drop", 64'(overflow), 64'd1);
        check("ovf_clr_vs_drop_level", 64'(cmd_level), 64'd4);
        repeat (2) step();
        vs_udr = 1'b0;
        repeat (4) step();
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;

        // Full with push and pop in the same cycle.
        ir_in  = 2'd1;
        sr     = pat(30);
        vs_udr = 1'b1;
        step();
        step();
        cmd_ready = 1'b1;
        #1;
        check("full_pp_take", 64'(take_action), 64'b0001);
        check("full_pp_popped", 64'(jdo), 64'(pat(10)));
        step();
        cmd_ready = 1'b0;
        check("full_pp_level", 64'(cmd_level), 64'd4);
        check("full_pp_ovf", 64'(overflow), 64'd0);
        repeat (2) step();
        vs_udr = 1'b0;
        repeat (4) step();
        exp_q[0] = pat(11);
        exp_q[1] = pat(12);
        exp_q[2] = pat(13);
        exp_q[3] = pat(30);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("full_pp_order%0d", i), 64'(jdo), 64'(exp_q[i]));
            step();
        end
        check("full_pp_drained", 64'(cmd_level), 64'd0);
        cmd_ready = 1'b0;

        // IR update pulse, not queued.
        ir_in  = 2'd1;
        vs_uir = 1'b1;
        step();
        check("uir_e1", 64'(ir_update), 64'd0);
        step();
        check("uir_e2", 64'(ir_update), 64'd0);
        step();
        check("uir_e3", 64'(ir_update), 64'b0010);
        check("uir_level", 64'(cmd_level), 64'd0);
        step();
        check("uir_e4", 64'(ir_update), 64'd0);
        repeat (2) step();
        vs_uir = 1'b0;
        repeat (4) step();

        // Concurrent update-IR and update-DR.
        ir_in  = 2'd3;
        sr     = pat(40);
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        repeat (3) step();
        check("both_upd", 64'(ir_update), 64'b1000);
        check("both_level", 64'(cmd_level), 64'd1);
        check("both_ir", 64'(cmd_ir), 64'd3);
        repeat (2) step();
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (4) step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("both_drained", 64'(cmd_level), 64'd0);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) send_udr(2'(i), pat(50 + i));
        check("rstq_level_before", 64'(cmd_level), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstq_valid", 64'(cmd_valid), 64'd0);
        check("rstq_level", 64'(cmd_level), 64'd0);
        check("rstq_ovf", 64'(overflow), 64'd0);
        check("rstq_jdo", 64'(jdo), 64'd0);
        repeat (2) step();
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rstq_post_take%0d", i), 64'(take_action), 64'd0);
            check($sformatf("rstq_post_upd%0d", i), 64'(ir_update), 64'd0);
            check($sformatf("rstq_post_valid%0d", i), 64'(cmd_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
